// File: rtl/alu_dispatch_if.sv
// rtl/alu_dispatch_if.sv - ALU dispatch types and issue/ALU/writeback bus interface
package alu_dispatch_pkg;
    localparam int IDX_W = 4;
    localparam int XLEN  = 32;

    typedef struct packed {
        logic       valid;
        logic [3:0] cause;
    } ex_t;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic [4:0]       rd;
        logic [3:0]       op;
        logic [XLEN-1:0]  operand_a;
        logic [XLEN-1:0]  operand_b;
        logic [XLEN-1:0]  operand_c;
    } fu_data_t;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic [4:0]       rd;
        logic [XLEN-1:0]  result;
        ex_t              ex;
    } fu_result_t;
endpackage

interface alu_dispatch_if #(
    parameter int DEPTH = 2
);
    import alu_dispatch_pkg::*;

    logic                       flush_i;
    logic                       issue_valid_i;
    logic                       issue_ready_o;
    fu_data_t                   issue_data_i;
    logic                       fu_valid_o;
    logic                       fu_ready_i;
    fu_data_t                   fu_data_o;
    logic                       fu_result_valid_i;
    logic                       fu_result_ready_o;
    fu_result_t                 fu_result_i;
    logic                       wb_valid_o;
    logic                       wb_ready_i;
    fu_result_t                 wb_result_o;
    logic                       order_err_o;
    logic [$clog2(DEPTH+1)-1:0] count_o;

    modport master (
        output flush_i, issue_valid_i, issue_data_i, fu_ready_i,
               fu_result_valid_i, fu_result_i, wb_ready_i,
        input  issue_ready_o, fu_valid_o, fu_data_o, fu_result_ready_o,
               wb_valid_o, wb_result_o, order_err_o, count_o
    );

    modport slave (
        input  flush_i, issue_valid_i, issue_data_i, fu_ready_i,
               fu_result_valid_i, fu_result_i, wb_ready_i,
        output issue_ready_o, fu_valid_o, fu_data_o, fu_result_ready_o,
               wb_valid_o, wb_result_o, order_err_o, count_o
    );
endinterface

// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - in-order ALU issue queue with result ordering check and writeback slot
module alu_dispatch
    import alu_dispatch_pkg::*;
#(
    parameter int DEPTH           = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    alu_dispatch_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    fu_data_t         q_mem [DEPTH];
    logic [PW-1:0]    q_wr, q_rd;
    logic [CW-1:0]    q_cnt;
    logic [IDX_W-1:0] idx_mem [MAX_OUTSTANDING];
    logic [IW-1:0]    i_wr, i_rd;
    logic [OW-1:0]    outstanding;
    fu_result_t       wb_q;
    logic             wb_v, err_q;

    logic             q_full, q_empty, push, dispatch, res_fire;
    logic             has_oldest, idx_pop, mismatch;
    logic [IDX_W-1:0] oldest;

    assign q_full   = (q_cnt == CW'(DEPTH));
    assign q_empty  = (q_cnt == '0);
    assign push     = bus.issue_valid_i && !q_full;
    assign dispatch = bus.fu_valid_o && bus.fu_ready_i;
    assign res_fire = bus.fu_result_valid_i && bus.fu_result_ready_o;

    // With nothing outstanding, a combinational ALU answers for the op being dispatched right now.
    assign has_oldest = (outstanding != '0) || dispatch;
    assign oldest     = (outstanding != '0) ? idx_mem[i_rd] : q_mem[q_rd].index;
    assign idx_pop    = res_fire && has_oldest;
    assign mismatch   = res_fire && (!has_oldest || (bus.fu_result_i.index != oldest));

    assign bus.issue_ready_o     = !q_full;
    assign bus.fu_valid_o        = !q_empty && (outstanding < OW'(MAX_OUTSTANDING));
    assign bus.fu_data_o         = q_mem[q_rd];
    assign bus.fu_result_ready_o = !wb_v || bus.wb_ready_i;
    assign bus.wb_valid_o        = wb_v;
    assign bus.wb_result_o       = wb_q;
    assign bus.order_err_o       = err_q;
    assign bus.count_o           = q_cnt;

    always_ff @(posedge clk_i) begin
        if (push)
            q_mem[q_wr] <= bus.issue_data_i;
        if (dispatch)
            idx_mem[i_wr] <= bus.fu_data_o.index;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_wr        <= '0;
            q_rd        <= '0;
            q_cnt       <= '0;
            i_wr        <= '0;
            i_rd        <= '0;
            outstanding <= '0;
            wb_v        <= 1'b0;
            wb_q        <= '0;
            err_q       <= 1'b0;
        end else if (bus.flush_i) begin
            q_wr        <= '0;
            q_rd        <= '0;
            q_cnt       <= '0;
            i_wr        <= '0;
            i_rd        <= '0;
            outstanding <= '0;
            wb_v        <= 1'b0;
        end else begin
            if (push)
                q_wr <= q_wr + 1'b1;
            if (dispatch)
                q_rd <= q_rd + 1'b1;
            q_cnt <= q_cnt + CW'(push) - CW'(dispatch);

            if (dispatch)
                i_wr <= (i_wr == IW'(MAX_OUTSTANDING - 1)) ? '0 : i_wr + 1'b1;
            if (idx_pop)
                i_rd <= (i_rd == IW'(MAX_OUTSTANDING - 1)) ? '0 : i_rd + 1'b1;
            outstanding <= outstanding + OW'(dispatch) - OW'(idx_pop);

            if (res_fire) begin
                wb_q <= bus.fu_result_i;
                wb_v <= 1'b1;
            end else if (bus.wb_ready_i) begin
                wb_v <= 1'b0;
            end

            if (mismatch)
                err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_dispatch.sv
// tb/tb_alu_dispatch.sv - scoreboard testbench for alu_dispatch
module tb_alu_dispatch;
    import alu_dispatch_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_dispatch_if #(.DEPTH(2)) bus();

    alu_dispatch #(.DEPTH(2), .MAX_OUTSTANDING(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    fu_result_t sb [$];
    fu_result_t mon_exp;

    logic       man = 1'b0;
    logic       alu_en = 1'b1;
    logic       man_fu_ready = 1'b0;
    logic       man_res_valid = 1'b0;
    fu_result_t man_res = '0;

    function automatic fu_result_t alu_model(input fu_data_t d);
        fu_result_t r;
        logic [31:0] t;
        r = '0;
        r.index = d.index;
        r.rd = d.rd;
        t = d.operand_a + d.operand_b;
        case (d.op)
            4'd0: r.result = t;
            4'd1: r.result = d.operand_a - d.operand_b;
            4'd2: r.result = d.operand_a & d.operand_b;
            4'd3: r.result = d.operand_a | d.operand_b;
            4'd4: r.result = d.operand_a ^ d.operand_b;
            4'd7: begin
                r.result   = {t[31:1], 1'b0};
                r.ex.valid = t[1];
                r.ex.cause = 4'd0;
            end
            default: r.result = d.operand_c;
        endcase
        return r;
    endfunction

    function automatic fu_data_t make_op(input int idx, input int op, input logic [31:0] a, input logic [31:0] b);
        fu_data_t d;
        d.index = IDX_W'(idx);
        d.rd = 5'(idx + 1);
        d.op = 4'(op);
        d.operand_a = a;
        d.operand_b = b;
        d.operand_c = 32'hC0DE_0000 | 32'(idx);
        return d;
    endfunction

    // Behavioural combinational ALU, or direct manual control of the ALU-side signals.
    assign bus.fu_ready_i        = man ? man_fu_ready : (alu_en && bus.fu_result_ready_o);
    assign bus.fu_result_valid_i = man ? man_res_valid : (bus.fu_valid_o && bus.fu_ready_i);
    assign bus.fu_result_i       = man ? man_res : alu_model(bus.fu_data_o);

    always @(negedge clk) begin
        if (rst_n && bus.wb_valid_o && bus.wb_ready_i) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got index %0d result %h, expected no writeback",
                         bus.wb_result_o.index, bus.wb_result_o.result);
            end else begin
                mon_exp = sb.pop_front();
                if (bus.wb_result_o !== mon_exp) begin
                    n_fail++;
                    $display("FAIL wb_result: got idx %0d rd %0d res %h ex %b/%0d, expected idx %0d rd %0d res %h ex %b/%0d",
                             bus.wb_result_o.index, bus.wb_result_o.rd, bus.wb_result_o.result,
                             bus.wb_result_o.ex.valid, bus.wb_result_o.ex.cause,
                             mon_exp.index, mon_exp.rd, mon_exp.result, mon_exp.ex.valid, mon_exp.ex.cause);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_op(input fu_data_t d, input bit track);
        int w = 0;
        bus.issue_valid_i = 1'b1;
        bus.issue_data_i = d;
        while (!bus.issue_ready_o && w < 60) begin
            tick();
            w++;
        end
        n_tests++;
        if (!bus.issue_ready_o) begin
            n_fail++;
            $display("FAIL issue_accept idx %0d: issue_ready_o=0 after %0d cycles, expected 1", d.index, w);
        end else if (track) begin
            sb.push_back(alu_model(d));
        end
        tick();
        bus.issue_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int w = 0;
        while (sb.size() != 0 && w < 200) begin
            tick();
            w++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d results still pending, expected 0", name, sb.size());
            sb.delete();
        end
        tick();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n_tests++;
        if ({bus.issue_ready_o, bus.fu_valid_o, bus.fu_result_ready_o, bus.wb_valid_o, bus.order_err_o} !== 5'b10100) begin
            n_fail++;
            $display("FAIL reset_flags: ready/fu_valid/res_ready/wb_valid/err=%b, expected 10100",
                     {bus.issue_ready_o, bus.fu_valid_o, bus.fu_result_ready_o, bus.wb_valid_o, bus.order_err_o});
        end
        n_tests++;
        if (bus.count_o !== 2'd0 || bus.wb_result_o !== '0) begin
            n_fail++;
            $display("FAIL reset_state: count=%0d wb_result=%h, expected 0 and 0", bus.count_o, bus.wb_result_o);
        end
    endtask

    task automatic test_basic();
        fu_data_t d;
        d = make_op(3, 0, 32'd5, 32'd7);
        bus.wb_ready_i = 1'b1;
        bus.issue_valid_i = 1'b1;
        bus.issue_data_i = d;
        sb.push_back(alu_model(d));
        tick();
        bus.issue_valid_i = 1'b0;
        n_tests++;
        if (bus.fu_valid_o !== 1'b1 || bus.fu_data_o.index !== 4'd3 || bus.count_o !== 2'd1) begin
            n_fail++;
            $display("FAIL basic_dispatch: fu_valid=%b idx=%0d count=%0d, expected 1 3 1",
                     bus.fu_valid_o, bus.fu_data_o.index, bus.count_o);
        end
        tick();
        n_tests++;
        if (bus.wb_valid_o !== 1'b1 || bus.wb_result_o.result !== 32'd12 || bus.wb_result_o.index !== 4'd3
            || bus.order_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_wb: wb_valid=%b res=%0d idx=%0d err=%b, expected 1 12 3 0",
                     bus.wb_valid_o, bus.wb_result_o.result, bus.wb_result_o.index, bus.order_err_o);
        end
        tick();
        n_tests++;
        if (bus.wb_valid_o !== 1'b0 || bus.count_o !== 2'd0) begin
            n_fail++;
            $display("FAIL basic_idle: wb_valid=%b count=%0d, expected 0 0", bus.wb_valid_o, bus.count_o);
        end
    endtask

    task automatic test_backpressure();
        bit done = 1'b0;
        int w = 0;
        bus.wb_ready_i = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    issue_op(make_op(i, i, 32'd100 + 32'(i), 32'd3), 1'b1);
                done = 1'b1;
            end
        join_none
        repeat (6) tick();
        n_tests++;
        if (bus.wb_valid_o !== 1'b1 || bus.wb_result_o.index !== 4'd0 || bus.fu_result_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_wb_hold: wb_valid=%b idx=%0d res_ready=%b, expected 1 0 0",
                     bus.wb_valid_o, bus.wb_result_o.index, bus.fu_result_ready_o);
        end
        n_tests++;
        if (bus.count_o !== 2'd2 || bus.issue_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: count=%0d issue_ready=%b, expected 2 0", bus.count_o, bus.issue_ready_o);
        end
        bus.wb_ready_i = 1'b1;
        while (!done && w < 100) begin
            tick();
            w++;
        end
        wait_drain("bp");
    endtask

    task automatic test_stall();
        fu_data_t held;
        bus.wb_ready_i = 1'b1;
        alu_en = 1'b0;
        issue_op(make_op(9, 3, 32'hF0F0_0000, 32'h0000_0F0F), 1'b1);
        held = bus.fu_data_o;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (bus.fu_valid_o !== 1'b1 || bus.fu_data_o !== held || held.index !== 4'd9) begin
                n_fail++;
                $display("FAIL stall_hold cycle %0d: fu_valid=%b data=%h, expected 1 and held idx 9 data",
                         i, bus.fu_valid_o, bus.fu_data_o);
            end
            tick();
        end
        alu_en = 1'b1;
        wait_drain("stall");
    endtask

    task automatic test_flush();
        bus.wb_ready_i = 1'b0;
        for (int i = 8; i < 11; i++)
            issue_op(make_op(i, 0, 32'(i), 32'd1), 1'b0);
        n_tests++;
        if (bus.count_o !== 2'd2 || bus.wb_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre: count=%0d wb_valid=%b, expected 2 1", bus.count_o, bus.wb_valid_o);
        end
        bus.flush_i = 1'b1;
        bus.issue_valid_i = 1'b1;
        bus.issue_data_i = make_op(11, 0, 32'd1, 32'd1);
        tick();
        bus.flush_i = 1'b0;
        bus.issue_valid_i = 1'b0;
        n_tests++;
        if (bus.count_o !== 2'd0 || bus.wb_valid_o !== 1'b0 || bus.fu_valid_o !== 1'b0 || bus.issue_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_clear: count=%0d wb_valid=%b fu_valid=%b issue_ready=%b, expected 0 0 0 1",
                     bus.count_o, bus.wb_valid_o, bus.fu_valid_o, bus.issue_ready_o);
        end
        bus.wb_ready_i = 1'b1;
        issue_op(make_op(12, 1, 32'd50, 32'd8), 1'b1);
        wait_drain("flush");
    endtask

    task automatic test_order();
        bus.wb_ready_i = 1'b1;
        man = 1'b1;
        man_fu_ready = 1'b1;
        man_res_valid = 1'b0;
        issue_op(make_op(4, 0, 32'd1, 32'd2), 1'b0);
        tick();
        man_fu_ready = 1'b0;
        n_tests++;
        if (bus.order_err_o !== 1'b0 || bus.fu_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL order_pre: err=%b fu_valid=%b, expected 0 0", bus.order_err_o, bus.fu_valid_o);
        end
        man_res = '0;
        man_res.index = 4'd5;
        man_res.rd = 5'd5;
        man_res.result = 32'hDEAD_BEEF;
        sb.push_back(man_res);
        man_res_valid = 1'b1;
        tick();
        man_res_valid = 1'b0;
        n_tests++;
        if (bus.order_err_o !== 1'b1 || bus.wb_valid_o !== 1'b1 || bus.wb_result_o.index !== 4'd5) begin
            n_fail++;
            $display("FAIL order_detect: err=%b wb_valid=%b idx=%0d, expected 1 1 5",
                     bus.order_err_o, bus.wb_valid_o, bus.wb_result_o.index);
        end
        man = 1'b0;
        issue_op(make_op(6, 2, 32'hFF00, 32'h0FF0), 1'b1);
        issue_op(make_op(7, 4, 32'hAAAA, 32'h5555), 1'b1);
        wait_drain("order");
        n_tests++;
        if (bus.order_err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL order_sticky: err=%b, expected 1", bus.order_err_o);
        end
    endtask

    task automatic test_back_to_back();
        bus.wb_ready_i = 1'b1;
        fork
            begin
                issue_op(make_op(1, 7, 32'h100, 32'd2), 1'b1);
                issue_op(make_op(2, 7, 32'h200, 32'd4), 1'b1);
                issue_op(make_op(3, 1, 32'd3, 32'd10), 1'b1);
                issue_op(make_op(4, 5, 32'd0, 32'd0), 1'b1);
                issue_op(make_op(5, 0, 32'hFFFF_FFFF, 32'd1), 1'b1);
                issue_op(make_op(6, 3, 32'h1, 32'h8000_0000), 1'b1);
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    bus.wb_ready_i = 1'($urandom_range(0, 1));
                    tick();
                end
                bus.wb_ready_i = 1'b1;
            end
        join
        wait_drain("b2b");
    endtask

    task automatic test_async_reset();
        bus.wb_ready_i = 1'b0;
        for (int i = 0; i < 3; i++)
            issue_op(make_op(i + 10, 0, 32'd9, 32'd9), 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.issue_ready_o, bus.fu_valid_o, bus.fu_result_ready_o, bus.wb_valid_o, bus.order_err_o} !== 5'b10100
            || bus.count_o !== 2'd0 || bus.wb_result_o !== '0) begin
            n_fail++;
            $display("FAIL async_reset: flags=%b count=%0d wb=%h, expected 10100 0 0",
                     {bus.issue_ready_o, bus.fu_valid_o, bus.fu_result_ready_o, bus.wb_valid_o, bus.order_err_o},
                     bus.count_o, bus.wb_result_o);
        end
        tick();
        rst_n = 1'b1;
        bus.wb_ready_i = 1'b1;
        issue_op(make_op(2, 4, 32'h1234, 32'h00FF), 1'b1);
        wait_drain("post_reset");
        n_tests++;
        if (bus.order_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_err: err=%b, expected 0", bus.order_err_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.flush_i = 1'b0;
        bus.issue_valid_i = 1'b0;
        bus.issue_data_i = '0;
        bus.wb_ready_i = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_stall();
        test_flush();
        test_order();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_dispatch.md
Name: alu_dispatch

Overview:
- Issue-side initiator for the single-cycle ALU functional unit.
- Accepts issued fu_data_t operations into a small in-order queue and drives them to the ALU over the valid/ready operand interface.
- Collects fu_result_t responses over the result valid/ready interface into a registered writeback slot.
- Checks that results return in dispatch order, and discards everything in flight on a pipeline flush.

Parameters:
- DEPTH, 2, operand queue entries (power of two, >=2).
- MAX_OUTSTANDING, 2, max dispatched-but-unreturned ops (>=1); sizes the index tracking FIFO.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard queue, outstanding ops and writeback slot
- issue_valid_i  in  1  upstream op valid
- issue_ready_o  out  1  queue can accept
- issue_data_i  in  fu_data_t  upstream op (index, rd, op, operand_a/b/c)
- fu_valid_o  out  1  op presented to ALU
- fu_ready_i  in  1  ALU accepts op
- fu_data_o  out  fu_data_t  head-of-queue op
- fu_result_valid_i  in  1  ALU result valid
- fu_result_ready_o  out  1  writeback slot can accept
- fu_result_i  in  fu_result_t  index, rd, result, ex
- wb_valid_o  out  1  writeback slot occupied
- wb_ready_i  in  1  writeback consumer accepts
- wb_result_o  out  fu_result_t  registered result incl. ex
- order_err_o  out  1  sticky: result index != oldest outstanding index
- count_o  out  $clog2(DEPTH+1)  queue occupancy

Behaviour:
- Reset (rst_ni low, async) and clear state:
  - queue empty; outstanding count 0.
  - wb_valid_o=0, wb_result_o='0, order_err_o=0, count_o=0.
  - issue_ready_o=1, fu_valid_o=0, fu_result_ready_o=1.
- Push on issue_valid_i && issue_ready_o; issue_ready_o = !full.
  - Registered only; a same-cycle pop does not raise ready when full.
- No bypass. Op accepted in cycle N is presented as fu_valid_o no earlier than N+1.
- fu_valid_o = !empty && (outstanding < MAX_OUTSTANDING); fu_data_o = head entry.
  - fu_data_o is held stable while fu_valid_o && !fu_ready_i.
  - Once asserted, fu_valid_o is not deasserted without a handshake, except on flush.
- Dispatch handshake (fu_valid_o && fu_ready_i):
  - pops the queue;
  - pushes head.index into the index FIFO;
  - outstanding +1.
- fu_result_ready_o = !wb_valid_o || wb_ready_i.
- Result handshake:
  - loads wb_result_o <= fu_result_i and sets wb_valid_o next cycle;
  - pops the index FIFO; outstanding -1.
- Same-cycle dispatch and result (normal for the combinational ALU): outstanding unchanged; both index FIFO push and pop occur.
- Result with outstanding==0 or index mismatch: order_err_o set sticky until reset. The result is still written back.
- Writeback: wb_valid_o clears on wb_ready_i unless reloaded the same cycle. Reload when full only when wb_ready_i=1 (no loss).
- wb_result_o.ex passes through unmodified, e.g. JALR misaligned target.
- flush_i (synchronous, highest priority):
  - next cycle queue empty, index FIFO empty, outstanding 0, wb_valid_o=0;
  - push and result in the flush cycle are dropped;
  - order_err_o unaffected.
- Pointer wrap: read/write pointers wrap modulo DEPTH.
  - Full/empty distinguished by count, not pointer equality alone.
- count_o = current occupancy (registered).

Test Plan:
- Basic: fu_ready_i tied to wb_ready_i=1, issue ADD index 3 a=5 b=7 at cycle 0 -> fu_valid_o cycle 1, result 12 index 3 handshakes cycle 1, wb_valid_o=1 cycle 2 with result 12, order_err_o=0.
- Backpressure: wb_ready_i=0, issue 4 ops -> first result held in wb slot, fu_result_ready_o=0, queue fills to count_o=2, issue_ready_o=0; release wb_ready_i -> ops drain in index order 0,1,2,3 with no loss or duplicate.
- Stall stability: fu_ready_i=0 for 5 cycles with queued op -> fu_valid_o stays 1 and fu_data_o bit-identical throughout.
- Flush: queue holding 2 ops, wb_valid_o=1, flush_i pulse concurrent with issue_valid_i -> next cycle count_o=0, wb_valid_o=0, fu_valid_o=0; new issue afterwards dispatches normally.
- Order check: force result index 5 while oldest outstanding is 4 -> order_err_o=1 the next cycle and stays 1 through later correct results; only reset clears it.
- Async reset mid-operation: assert rst_ni low between clock edges with full queue -> all outputs at reset values immediately, without a clock edge.
